// File: rtl/spi_pkg.sv
// Shared SPI definitions: CPOL/CPHA mode encoding, CSMODE field positions and
// the slave shifter state encoding.
package spi_pkg;

    // {CPOL, CPHA}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    localparam int unsigned CSMODE_CPHA_BIT = 0;
    localparam int unsigned CSMODE_CPOL_BIT = 1;
    localparam int unsigned CSMODE_REV_BIT  = 2;
    localparam int unsigned CSMODE_LEN_LSB  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } shift_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty derive from the level.
// The head reads as zero while empty.
module spi_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full, empty, do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop_ready & ~empty;
    // A pop on a full FIFO frees the slot for a same-cycle push.
    assign do_push = push_valid & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign push_ready = ~full;
    assign pop_valid  = ~empty;
    assign pop_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign level      = level_q;

endmodule

// File: rtl/spi_slave_trx_fifo.sv
// SPI slave transceiver with TX/RX FIFOs, variable character length, all four
// CPOL/CPHA modes and both bit orders; SPI pins oversampled in the system clock.
module spi_slave_trx_fifo
    import spi_pkg::*;
#(
    parameter int unsigned CHAR_NBITS = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LEN_W = $clog2(CHAR_NBITS),
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESET,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_REV,
    input  logic [LEN_W-1:0]      S_CHAR_LEN,
    input  logic                  S_SPI_CS,
    input  logic                  S_SPI_SCK,
    input  logic                  S_SPI_MOSI,
    output logic                  S_SPI_MISO,
    output logic                  S_SPI_MISO_OE,
    input  logic [CHAR_NBITS-1:0] S_TX_DATA,
    input  logic                  S_TX_VALID,
    output logic                  S_TX_READY,
    output logic [CHAR_NBITS-1:0] S_RX_DATA,
    output logic                  S_RX_VALID,
    input  logic                  S_RX_READY,
    output logic [LVL_W-1:0]      S_TX_LEVEL,
    output logic [LVL_W-1:0]      S_RX_LEVEL,
    output logic                  S_CHAR_DONE,
    output logic                  S_RX_OVF,
    output logic                  S_TX_UNF,
    input  logic                  S_ERR_CLR
);

    localparam int unsigned CFG_W = CSMODE_LEN_LSB + LEN_W;

    shift_state_e          state_q, state_d;
    logic [2:0]            sck_sync_q, sck_sync_d;
    logic [2:0]            cs_sync_q, cs_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    logic [CFG_W-1:0]      cfg_q, cfg_d;
    logic [CHAR_NBITS-1:0] tx_q, tx_d;
    logic [CHAR_NBITS-1:0] rx_q, rx_d;
    logic [LEN_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  done_q, done_d;
    logic                  rx_ovf_q, rx_ovf_d;
    logic                  tx_unf_q, tx_unf_d;

    logic                  sck_rise, sck_fall, cs_s, cs_fall, mosi_s;
    logic                  sample_edge, shift_edge;
    logic                  cfg_rev;
    logic [LEN_W-1:0]      cfg_len;
    spi_mode_e             cfg_mode;
    logic [CHAR_NBITS-1:0] rx_next;
    logic                  tx_pop, tx_avail, rx_push_ready, tx_unf_set, rx_ovf_set;
    logic [CHAR_NBITS-1:0] tx_head;

    function automatic logic [LEN_W-1:0] bit_pos(input logic rev, input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] idx);
        bit_pos = rev ? (len - idx) : idx;
    endfunction

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_s     = cs_sync_q[1];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_s   = mosi_sync_q[1];

    assign cfg_rev  = cfg_q[CSMODE_REV_BIT];
    assign cfg_len  = cfg_q[CSMODE_LEN_LSB +: LEN_W];
    assign cfg_mode = spi_mode_e'(cfg_q[CSMODE_CPOL_BIT:CSMODE_CPHA_BIT]);

    always_comb begin
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
        case (cfg_mode)
            SPI_MODE0: begin sample_edge = sck_rise; shift_edge = sck_fall; end
            SPI_MODE1: begin sample_edge = sck_fall; shift_edge = sck_rise; end
            SPI_MODE2: begin sample_edge = sck_fall; shift_edge = sck_rise; end
            SPI_MODE3: begin sample_edge = sck_rise; shift_edge = sck_fall; end
            default:   begin sample_edge = 1'b0;     shift_edge = 1'b0;     end
        endcase
    end

    // The completed word is still in rx_q during the following LOAD cycle.
    assign rx_ovf_set = done_q & ~rx_push_ready & ~S_RX_READY;

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[1:0], S_SPI_SCK};
        cs_sync_d   = {cs_sync_q[1:0], S_SPI_CS};
        mosi_sync_d = {mosi_sync_q[0], S_SPI_MOSI};
        cfg_d       = cfg_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        done_d      = 1'b0;
        tx_pop      = 1'b0;
        tx_unf_set  = 1'b0;
        rx_next     = rx_q;

        if (!S_ENABLE || cs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_LOAD;
                        miso_oe_d = 1'b1;
                    end
                end
                ST_LOAD: begin
                    cfg_d      = {S_CHAR_LEN, S_REV, S_CPOL, S_CPHA};
                    tx_pop     = 1'b1;
                    tx_d       = tx_head;
                    tx_unf_set = ~tx_avail;
                    rx_d       = '0;
                    bit_cnt_d  = '0;
                    if (!S_CPHA) begin
                        miso_d   = tx_head[bit_pos(S_REV, S_CHAR_LEN, '0)];
                        tx_cnt_d = LEN_W'(1);
                    end else begin
                        miso_d   = 1'b0;
                        tx_cnt_d = '0;
                    end
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        if (cfg_rev) begin
                            rx_next = {rx_q[CHAR_NBITS-2:0], mosi_s};
                        end else begin
                            rx_next[bit_cnt_q] = mosi_s;
                        end
                        rx_d = rx_next;
                        if (bit_cnt_q == cfg_len) begin
                            bit_cnt_d = '0;
                            done_d    = 1'b1;
                            state_d   = ST_LOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + LEN_W'(1);
                        end
                    // CPHA=0: the trailing edge closing the previous character must not shift.
                    end else if (shift_edge && (cfg_q[CSMODE_CPHA_BIT] || bit_cnt_q != '0)) begin
                        miso_d   = tx_q[bit_pos(cfg_rev, cfg_len, tx_cnt_q)];
                        tx_cnt_d = tx_cnt_q + LEN_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~S_ERR_CLR);
        tx_unf_d = tx_unf_set | (tx_unf_q & ~S_ERR_CLR);
    end

    always_ff @(posedge S_SYSCLK or posedge S_RESET) begin
        if (S_RESET) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            cfg_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            tx_cnt_q    <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            rx_ovf_q    <= 1'b0;
            tx_unf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cfg_q       <= cfg_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            done_q      <= done_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_unf_q    <= tx_unf_d;
        end
    end

    spi_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(CHAR_NBITS)
    ) u_tx_fifo (
        .clk        (S_SYSCLK),
        .rst        (S_RESET),
        .push_valid (S_TX_VALID),
        .push_data  (S_TX_DATA),
        .push_ready (S_TX_READY),
        .pop_ready  (tx_pop),
        .pop_valid  (tx_avail),
        .pop_data   (tx_head),
        .level      (S_TX_LEVEL)
    );

    spi_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(CHAR_NBITS)
    ) u_rx_fifo (
        .clk        (S_SYSCLK),
        .rst        (S_RESET),
        .push_valid (done_q),
        .push_data  (rx_q),
        .push_ready (rx_push_ready),
        .pop_ready  (S_RX_READY),
        .pop_valid  (S_RX_VALID),
        .pop_data   (S_RX_DATA),
        .level      (S_RX_LEVEL)
    );

    assign S_SPI_MISO    = miso_q;
    assign S_SPI_MISO_OE = miso_oe_q;
    assign S_CHAR_DONE   = done_q;
    assign S_RX_OVF      = rx_ovf_q;
    assign S_TX_UNF      = tx_unf_q;

endmodule
